// File: rtl/pwm_ramp_sequencer.sv
// APB master that programs the PWM peripheral (divider, duty, enable) and then
// ramps the duty register toward a target in fixed steps with a programmable dwell.
module pwm_ramp_sequencer #(
  parameter int          DUTY_W    = 9,
  parameter int          HOLD_W    = 16,
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] ADDR_EN   = 32'd0,
  parameter logic [31:0] ADDR_DUTY = 32'd1,
  parameter logic [31:0] ADDR_DIV  = 32'd2
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       cfg_div,
  input  logic [DUTY_W-1:0] cfg_start_duty,
  input  logic [DUTY_W-1:0] cfg_target_duty,
  input  logic [DUTY_W-1:0] cfg_step,
  input  logic [HOLD_W-1:0] cfg_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [31:0]       PWDATA,
  input  logic              PREADY
);

  localparam int              TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_W_DIV, S_W_DUTY, S_W_EN, S_HOLD, S_W_STEP, S_W_OFF, S_FIN
  } state_e;

  state_e              state_q, state_d;
  logic                access_q, access_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                abort_q, abort_d;
  logic                err_q, err_d;
  logic [31:0]         div_q, div_d;
  logic [DUTY_W-1:0]   start_q, start_d;
  logic [DUTY_W-1:0]   target_q, target_d;
  logic [DUTY_W-1:0]   step_q, step_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [DUTY_W-1:0]   cur_q, cur_d;

  logic                is_write;
  logic                abort_any;
  logic                hold_done;
  logic [31:0]         wr_addr;
  logic [31:0]         wr_data;
  logic [DUTY_W:0]     sum;
  logic [DUTY_W-1:0]   next_duty;
  state_e              after_write;

  // Next ramp point: the sum is one bit wider so it saturates at target instead of wrapping.
  always_comb begin
    sum       = {1'b0, cur_q} + {1'b0, step_q};
    next_duty = target_q;
    if (step_q == '0) begin
      next_duty = target_q;
    end else if (cur_q < target_q) begin
      next_duty = (sum >= {1'b0, target_q}) ? target_q : sum[DUTY_W-1:0];
    end else if (cur_q > target_q) begin
      next_duty = ((cur_q - target_q) <= step_q) ? target_q : (cur_q - step_q);
    end
  end

  assign is_write  = (state_q == S_W_DIV) || (state_q == S_W_DUTY) || (state_q == S_W_EN) ||
                     (state_q == S_W_STEP) || (state_q == S_W_OFF);
  assign abort_any = abort_q || abort;
  assign hold_done = ({1'b0, hold_cnt_q} + (HOLD_W + 1)'(1)) >= {1'b0, hold_q};

  always_comb begin
    wr_addr     = ADDR_EN;
    wr_data     = '0;
    after_write = S_IDLE;
    case (state_q)
      S_W_DIV: begin
        wr_addr     = ADDR_DIV;
        wr_data     = div_q;
        after_write = abort_any ? S_W_OFF : S_W_DUTY;
      end
      S_W_DUTY: begin
        wr_addr     = ADDR_DUTY;
        wr_data     = {{(32-DUTY_W){1'b0}}, cur_q};
        after_write = abort_any ? S_W_OFF : S_W_EN;
      end
      S_W_EN: begin
        wr_data     = 32'd1;
        after_write = abort_any ? S_W_OFF : ((cur_q == target_q) ? S_FIN : S_HOLD);
      end
      S_W_STEP: begin
        wr_addr     = ADDR_DUTY;
        wr_data     = {{(32-DUTY_W){1'b0}}, cur_q};
        after_write = abort_any ? S_W_OFF : ((cur_q == target_q) ? S_FIN : S_HOLD);
      end
      default: ;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d    = state_q;
    access_d   = access_q;
    tmo_d      = tmo_q;
    hold_cnt_d = hold_cnt_q;
    abort_d    = abort_q;
    err_d      = err_q;
    div_d      = div_q;
    start_d    = start_q;
    target_d   = target_q;
    step_d     = step_q;
    hold_d     = hold_q;
    cur_d      = cur_q;
    PSEL       = 1'b0;
    PENABLE    = 1'b0;
    PWRITE     = 1'b0;
    PADDR      = '0;
    PWDATA     = '0;
    done       = 1'b0;

    if (state_q != S_IDLE && abort) abort_d = 1'b1;

    if (is_write) begin
      PSEL    = 1'b1;
      PENABLE = access_q;
      PWRITE  = 1'b1;
      PADDR   = wr_addr;
      PWDATA  = wr_data;
      if (!access_q) begin
        access_d = 1'b1;
        tmo_d    = '0;
      end else if (PREADY) begin
        access_d   = 1'b0;
        hold_cnt_d = '0;
        state_d    = after_write;
      end else if (tmo_q == TMO_LAST) begin
        access_d = 1'b0;
        err_d    = 1'b1;
        state_d  = S_IDLE;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          div_d    = cfg_div;
          start_d  = cfg_start_duty;
          target_d = cfg_target_duty;
          step_d   = cfg_step;
          hold_d   = cfg_hold;
          cur_d    = cfg_start_duty;
          err_d    = 1'b0;
          access_d = 1'b0;
          state_d  = S_W_DIV;
        end
      end
      S_HOLD: begin
        if (abort_any) begin
          state_d = S_W_OFF;
        end else if (hold_done) begin
          cur_d   = next_duty;
          state_d = S_W_STEP;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: ;
    endcase

    if (state_d == S_IDLE) abort_d = 1'b0;
  end

  // NOTE: all state, including the shadow config registers, is cleared by the async reset so outputs are defined immediately.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= S_IDLE;
      access_q   <= 1'b0;
      tmo_q      <= '0;
      hold_cnt_q <= '0;
      abort_q    <= 1'b0;
      err_q      <= 1'b0;
      div_q      <= '0;
      start_q    <= '0;
      target_q   <= '0;
      step_q     <= '0;
      hold_q     <= '0;
      cur_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q    <= state_d;
      access_q   <= access_d;
      tmo_q      <= tmo_d;
      hold_cnt_q <= hold_cnt_d;
      abort_q    <= abort_d;
      err_q      <= err_d;
      div_q      <= div_d;
      start_q    <= start_d;
      target_q   <= target_d;
      step_q     <= step_d;
      hold_q     <= hold_d;
      cur_q      <= cur_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign err  = err_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Scoreboard bench for pwm_ramp_sequencer: expected APB writes are queued by the
// stimulus and popped by a monitor on every completed transfer.
module tb_pwm_ramp_sequencer;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] cfg_div = '0;
  logic [8:0]  cfg_start_duty = '0;
  logic [8:0]  cfg_target_duty = '0;
  logic [8:0]  cfg_step = '0;
  logic [15:0] cfg_hold = '0;
  logic        busy, done, err;
  logic [31:0] PADDR, PWDATA;
  logic        PSEL, PENABLE, PWRITE, PREADY;

  int   ready_mode = 1;  // 0: never ready, 1: zero-wait, 2: one wait state
  logic ready_late = 1'b0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  done_cnt = 0;

  pwm_ramp_sequencer dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .start(start), .abort(abort),
    .cfg_div(cfg_div), .cfg_start_duty(cfg_start_duty), .cfg_target_duty(cfg_target_duty),
    .cfg_step(cfg_step), .cfg_hold(cfg_hold), .busy(busy), .done(done), .err(err),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) ready_late <= 1'b0;
    else          ready_late <= PSEL && PENABLE && !ready_late;
  end

  assign PREADY = (ready_mode == 1) ? 1'b1 : ((ready_mode == 2) ? ready_late : 1'b0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] addr, input logic [31:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic set_cfg(input logic [31:0] div, input logic [8:0] s, input logic [8:0] t,
                         input logic [8:0] st, input logic [15:0] h);
    cfg_div = div;
    cfg_start_duty = s;
    cfg_target_duty = t;
    cfg_step = st;
    cfg_hold = h;
  endtask

  // Monitor: pops one expected write per completed APB transfer and counts done pulses.
  initial begin
    wr_t e;
    forever begin
      @(negedge PCLK);
      if (PRESETn) begin
        if (done) done_cnt++;
        if (PSEL && PENABLE && PREADY) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: got addr %0d data %0d expected none", PADDR, PWDATA);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", PADDR, e.addr);
            check("wr_data", PWDATA, e.data);
            check("pwrite", 32'(PWRITE), 32'd1);
          end
        end
      end
    end
  end

  // Pulses start, then counts busy/PSEL/PENABLE cycles until the sequencer returns to idle.
  task automatic run(input logic abort_with_start, input int abort_at,
                     output int busy_c, output int psel_c, output int pen_c, output logic err1);
    done_cnt = 0;
    busy_c = 0;
    psel_c = 0;
    pen_c = 0;
    err1 = 1'b1;
    @(negedge PCLK);
    start = 1'b1;
    abort = abort_with_start;
    @(negedge PCLK);
    start = 1'b0;
    abort = 1'b0;
    for (int k = 1; k <= 2000 && busy; k++) begin
      busy_c++;
      if (PSEL) psel_c++;
      if (PENABLE) pen_c++;
      if (k == 1) begin
        err1 = err;
        cfg_div = $urandom;
        cfg_start_duty = 9'($urandom);
        cfg_target_duty = 9'($urandom);
        cfg_step = 9'($urandom);
        cfg_hold = 16'($urandom);
      end
      abort = (k == abort_at);
      @(negedge PCLK);
    end
    abort = 1'b0;
    if (busy) check("busy_bound", 32'(busy), 32'd0);
  endtask

  int   bc, pc, ec;
  logic e1;

  initial begin
    ready_mode = 1;
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("rst_psel", 32'(PSEL), 32'd0);
    check("rst_penable", 32'(PENABLE), 32'd0);
    check("rst_pwrite", 32'(PWRITE), 32'd0);
    check("rst_paddr", PADDR, 32'd0);
    check("rst_pwdata", PWDATA, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Soft-start ramp 0 -> 100 in steps of 25, zero-wait slave.
    set_cfg(32'd4, 9'd0, 9'd100, 9'd25, 16'd3);
    push(2, 4); push(1, 0); push(0, 1); push(1, 25); push(1, 50); push(1, 75); push(1, 100);
    run(1'b0, 0, bc, pc, ec, e1);
    check("up_busy_cycles", 32'(bc), 32'd27);
    check("up_done_cnt", 32'(done_cnt), 32'd1);
    check("up_queue_left", 32'(exp_q.size()), 32'd0);

    // Ramp down with clamping, one wait state per transfer.
    ready_mode = 2;
    set_cfg(32'd9, 9'd200, 9'd50, 9'd60, 16'd0);
    push(2, 9); push(1, 200); push(0, 1); push(1, 140); push(1, 80); push(1, 50);
    run(1'b0, 0, bc, pc, ec, e1);
    check("down_busy_cycles", 32'(bc), 32'd22);
    check("down_done_cnt", 32'(done_cnt), 32'd1);
    check("down_queue_left", 32'(exp_q.size()), 32'd0);

    // start == target, with abort arriving together with start (abort ignored).
    ready_mode = 1;
    set_cfg(32'd7, 9'd300, 9'd300, 9'd5, 16'd2);
    push(2, 7); push(1, 300); push(0, 1);
    run(1'b1, 0, bc, pc, ec, e1);
    check("flat_busy_cycles", 32'(bc), 32'd7);
    check("flat_done_cnt", 32'(done_cnt), 32'd1);
    check("flat_queue_left", 32'(exp_q.size()), 32'd0);

    // Abort at the first cycle of the second HOLD.
    set_cfg(32'd4, 9'd0, 9'd100, 9'd25, 16'd3);
    push(2, 4); push(1, 0); push(0, 1); push(1, 25); push(0, 0);
    run(1'b0, 12, bc, pc, ec, e1);
    check("abort_busy_cycles", 32'(bc), 32'd14);
    check("abort_done_cnt", 32'(done_cnt), 32'd0);
    check("abort_queue_left", 32'(exp_q.size()), 32'd0);

    // PREADY stuck low: 1 SETUP + 16 ACCESS cycles, then error.
    ready_mode = 0;
    set_cfg(32'd4, 9'd0, 9'd100, 9'd25, 16'd3);
    run(1'b0, 0, bc, pc, ec, e1);
    check("tmo_busy_cycles", 32'(bc), 32'd17);
    check("tmo_psel_cycles", 32'(pc), 32'd17);
    check("tmo_access_cycles", 32'(ec), 32'd16);
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_done_cnt", 32'(done_cnt), 32'd0);

    // Next start clears the sticky error.
    ready_mode = 1;
    set_cfg(32'd7, 9'd300, 9'd300, 9'd5, 16'd2);
    push(2, 7); push(1, 300); push(0, 1);
    run(1'b0, 0, bc, pc, ec, e1);
    check("clr_err_first_cycle", 32'(e1), 32'd0);
    check("clr_busy_cycles", 32'(bc), 32'd7);
    check("clr_done_cnt", 32'(done_cnt), 32'd1);
    check("clr_err_end", 32'(err), 32'd0);

    // Reset asserted during ACCESS drops the bus at once.
    ready_mode = 0;
    @(negedge PCLK);
    start = 1'b1;
    @(negedge PCLK);
    start = 1'b0;
    for (int k = 0; k < 20 && !PENABLE; k++) @(negedge PCLK);
    check("mid_reached_access", 32'(PENABLE), 32'd1);
    #2 PRESETn = 1'b0;
    #1;
    check("mid_rst_psel", 32'(PSEL), 32'd0);
    check("mid_rst_penable", 32'(PENABLE), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    ready_mode = 1;
    set_cfg(32'd4, 9'd0, 9'd100, 9'd25, 16'd3);
    push(2, 4); push(1, 0); push(0, 1); push(1, 25); push(1, 50); push(1, 75); push(1, 100);
    run(1'b0, 0, bc, pc, ec, e1);
    check("post_rst_busy_cycles", 32'(bc), 32'd27);
    check("post_rst_done_cnt", 32'(done_cnt), 32'd1);
    check("post_rst_queue_left", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
